alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters (e.g. main datapath and a debug/test port).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block registers operands, drives the ALU, captures the result and holds it until the requester accepts it.
- Arbitration is round-robin, and one operation is in flight at a time.

Parameters:
- W, 32, operand/result width (ALU is fixed at 32; W exists for bench reuse only, must stay 32 in the CPU build)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  W  operand A
- req0_b  input  W  operand B
- req0_op  input  3  ALUOp code (000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra)
- rsp0_valid  output  1  result for requester 0 available
- rsp0_ready  input  1  requester 0 takes result
- rsp0_data  output  W  result
- rsp0_err  output  1  op code was unsupported (110/111)
- req1_*, rsp1_*  same as requester 0, for requester 1
- alu_a  output  W  to ALU A
- alu_b  output  W  to ALU B
- alu_op  output  3  to ALU ALUOp
- alu_c  input  W  from ALU C

Behaviour:
- FSM states:
  - IDLE: wait for a request; grant per round-robin.
  - EXEC: registered operands drive the ALU; alu_c is captured.
  - RESP: result is held for the granted requester.
- Transitions:
  - IDLE->EXEC when any reqN_valid.
  - EXEC->RESP unconditionally.
  - RESP->IDLE when the granted rspN_valid && rspN_ready.
- Grant:
  - Computed combinationally in IDLE.
  - If only one valid, that one wins.
  - If both valid, the requester not equal to last_grant wins.
  - last_grant resets to 1, so req0 wins the first tie.
  - last_grant updates on acceptance.
- Ready:
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid.
  - Combinational and never asserted outside IDLE.
  - The request is accepted on the rising edge where valid && ready; a, b, op and the grant id are latched into registers.
- ALU drive:
  - alu_a/alu_b/alu_op come from the operand registers at all times, never from the request ports directly.
  - Reset values are 0/0/000.
- Capture:
  - At the end of EXEC, result_reg <= alu_c and err_reg <= (op_reg==110 || op_reg==111).
  - If err, result_reg <= 0 instead. The ALU holds a stale C for these codes, so its value must not be forwarded.
- Response:
  - rspN_valid = (state==RESP) && id==N.
  - rspN_data = result_reg and rspN_err = err_reg for the granted N; the other port shows data 0 and err 0.
  - Data is stable while valid && !ready.
- Latency: accept at edge k; EXEC is cycle k+1; rsp_valid is high from cycle k+2. Minimum back-to-back issue interval is 3 cycles (accept, EXEC, RESP with immediate ready).
- Simultaneous events:
  - A requester may hold req_valid high while awaiting its own response; it is not granted until the FSM returns to IDLE.
  - A new grant can be issued in the IDLE cycle right after the response handshake. No same-cycle RESP->accept bypass.
- Reset mid-operation:
  - state<=IDLE, last_grant<=1, operand/result/err registers <=0, all valid/ready outputs 0.
  - The in-flight operation is dropped with no response.
- Shift rules: ALU shift amount is the full B; the arbiter passes B unmodified and does not mask to 5 bits.

Test Plan:
- Reset then req0 only: a=5, b=3, op=000 -> req0_ready high in cycle 0; rsp0_valid at cycle 2 with data 8, err 0; rsp1_valid stays 0.
- Both valid on the same cycle after reset: req0 (10-4, op 001) and req1 (0xF0 & 0x3C, op 010) -> req0 served first with data 6; then req1 with data 0x30; round-robin order verified over 4 further tie rounds (alternating).
- Backpressure: req1 op 101, a=0x80000000, b=4, rsp1_ready held 0 for 5 cycles -> rsp1_valid stays high, data 0xF8000000 stable; req0_valid high all the while gets no ready until 1 cycle after the rsp1 handshake.
- Unsupported op: req0 op 110, a=1, b=1 -> rsp0_err=1, rsp0_data=0; a following op 011 (0x0F | 0xF0) returns 0xFF with err 0.
- Reset asserted asynchronously during EXEC, mid-cycle -> all outputs 0 immediately; after release, no stale rsp appears; the next tie grants req0.
- Logical shift: op 100, a=0x80000000, b=31 -> 0x00000001; alu_a/alu_b/alu_op observed constant during EXEC and RESP.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. Only one
// operation is in flight at a time. The block accepts a request, drives the
// ALU from its operand registers for one cycle (EXEC), captures the result,
// and holds it on the granted requester's response channel (RESP) until that
// requester takes it. When both requesters are waiting, the grant is
// round-robin.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_a/b/op           operands and ALUOp code for requester N
//   rspN_valid/ready      response handshake for requester N
//   rspN_data/err         result and unsupported-op flag for requester N
//   alu_a/b/op            operand register values sent to the ALU
//   alu_c                 ALU result
//
// ALUOp codes: 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra.
// Codes 110/111 are unsupported: they return data 0 with err set.
// B is passed to the ALU unmodified, so shift amounts above 31 are possible.

module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp0_err,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         rsp1_err,

  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_nextState;

  logic           r_lastGrant;
  logic           r_id;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2:0]     r_op;
  logic [W-1:0]   r_result;
  logic           r_err;

  logic           w_grant;
  logic           w_accept;
  logic           w_rspDone;
  logic           w_opErr;
  logic           w_inIdle;
  logic           w_inResp;

  assign w_inIdle = (r_state == IDLE);
  assign w_inResp = (r_state == RESP);

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not granted last time wins. r_lastGrant resets to 1 so req0 takes
  // the first tie.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_lastGrant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Ready is gated with reset so no handshake can appear while reset is held.
  assign req0_ready = !reset && w_inIdle && !w_grant && req0_valid;
  assign req1_ready = !reset && w_inIdle &&  w_grant && req1_valid;
  assign w_accept   = req0_ready || req1_ready;

  assign rsp0_valid = w_inResp && !r_id;
  assign rsp1_valid = w_inResp &&  r_id;
  assign rsp0_data  = rsp0_valid ? r_result : '0;
  assign rsp1_data  = rsp1_valid ? r_result : '0;
  assign rsp0_err   = rsp0_valid && r_err;
  assign rsp1_err   = rsp1_valid && r_err;

  assign w_rspDone  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // The ALU only ever sees registered operands, never the request ports.
  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign alu_op = r_op;

  // Codes 110 and 111 are unsupported.
  assign w_opErr = r_op[2] && r_op[1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. EXEC always lasts exactly one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_nextState = EXEC;
      EXEC:                   w_nextState = RESP;
      RESP:    if (w_rspDone) w_nextState = IDLE;
      default:                w_nextState = IDLE;
    endcase
  end

  // Operand latch on acceptance and result capture at the end of EXEC.
  // For unsupported codes the ALU output is stale, so zero is stored instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastGrant <= 1'b1;
      r_id        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 3'b000;
      r_result    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lastGrant <= w_grant;
        r_id        <= w_grant;
        r_a         <= w_grant ? req1_a  : req0_a;
        r_b         <= w_grant ? req1_b  : req0_b;
        r_op        <= w_grant ? req1_op : req0_op;
      end
      if (r_state == EXEC) begin
        r_err    <= w_opErr;
        r_result <= w_opErr ? '0 : alu_c;
      end
    end
  end

endmodule
